// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - frame controller driving a parallel-load left shift register as a serial transmitter
// Optional parity bit after each frame: define SHIFT_REG_CTRL_PARITY_EN.
module shift_reg_ctrl #(
  parameter int   WIDTH      = 8,
  parameter logic FILL_BIT   = 1'b0,
  parameter int   GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             sr_enable,
  output logic             sr_load,
  output logic             sr_sclr,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_shiftin,
  input  logic             sr_shiftout,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0]      GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SHIFT_REG_CTRL_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LAST, S_PARITY, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LAST, S_GAP} state_t;
`endif

  // Where a completed frame goes: through the inter-frame gap only if one is configured.
  localparam state_t POST_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_cnt;
  logic [WIDTH-1:0] data_q;
  logic             ser_valid_q;
  logic             capture;
  logic             abort_act;
  logic             par_phase;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic             parity_q;
`endif

  assign abort_act  = abort && (state != S_IDLE);
  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign sr_data    = data_q;
  assign sr_shiftin = FILL_BIT;

`ifdef SHIFT_REG_CTRL_PARITY_EN
  assign par_phase = (state == S_PARITY);
  // The parity bit is presented by the controller itself, not by the shift register.
  assign ser_valid = (ser_valid_q || par_phase) && !abort_act;
  assign ser_out   = ser_valid && (par_phase ? parity_q : sr_shiftout);
`else
  assign par_phase = 1'b0;
  assign ser_valid = ser_valid_q && !abort_act;
  assign ser_out   = ser_valid && sr_shiftout;
`endif

  // State, counters, captured word and the one-cycle-late serial qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      data_q      <= '0;
      ser_valid_q <= 1'b0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (capture) begin
        data_q <= in_data;
`ifdef SHIFT_REG_CTRL_PARITY_EN
        parity_q <= ^in_data;
`endif
      end
      if (state == S_LOAD)
        bit_cnt <= '0;
      else if (state == S_SHIFT)
        bit_cnt <= bit_cnt + CNT_W'(1);
      if (state == S_GAP)
        gap_cnt <= gap_cnt + 8'd1;
      else
        gap_cnt <= '0;
      // shiftout changes on the shift edge, so its bit is valid the cycle after SHIFT
      ser_valid_q <= (state == S_SHIFT) && !abort_act;
    end
  end

  // Next state and shift register controls; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    sr_enable = 1'b0;
    sr_load   = 1'b0;
    sr_sclr   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !abort) begin
          capture   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        sr_enable = 1'b1;
        sr_load   = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        sr_enable = 1'b1;
        if (bit_cnt == BIT_LAST)
          state_nxt = S_LAST;
      end
      S_LAST: begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
        state_nxt = S_PARITY;
`else
        done      = 1'b1;
        state_nxt = POST_FRAME;
`endif
      end
`ifdef SHIFT_REG_CTRL_PARITY_EN
      S_PARITY: begin
        done      = 1'b1;
        state_nxt = POST_FRAME;
      end
`endif
      S_GAP: begin
        if (gap_cnt == GAP_LAST)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) begin
      sr_enable = 1'b1;
      sr_sclr   = 1'b1;
      sr_load   = 1'b0;
      done      = 1'b0;
      state_nxt = S_IDLE;
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - scoreboard bench for shift_reg_ctrl with a behavioural shift register
module tb_shift_reg_ctrl;

  localparam int W = 8;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic         clk, rst_n;
  logic         in_valid, abort, in_ready;
  logic [W-1:0] in_data, sr_data;
  logic         sr_enable, sr_load, sr_sclr, sr_shiftin, sr_shiftout;
  logic         ser_out, ser_valid, busy, done;

  logic         in_valid2, abort2, in_ready2;
  logic [W-1:0] in_data2, sr_data2;
  logic         sr_enable2, sr_load2, sr_sclr2, sr_shiftin2, sr_shiftout2;
  logic         ser_out2, ser_valid2, busy2, done2;

  logic [W-1:0] sr_q, sr_q2;
  exp_t         sb[$];
  exp_t         mon_e;
  logic         mon_en;
  int           n_assert, n_fail;

  shift_reg_ctrl #(.WIDTH(W), .FILL_BIT(1'b0), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .sr_enable(sr_enable), .sr_load(sr_load), .sr_sclr(sr_sclr),
    .sr_data(sr_data), .sr_shiftin(sr_shiftin), .sr_shiftout(sr_shiftout),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  shift_reg_ctrl #(.WIDTH(W), .FILL_BIT(1'b0), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .abort(abort2), .sr_enable(sr_enable2), .sr_load(sr_load2), .sr_sclr(sr_sclr2),
    .sr_data(sr_data2), .sr_shiftin(sr_shiftin2), .sr_shiftout(sr_shiftout2),
    .ser_out(ser_out2), .ser_valid(ser_valid2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External left shift register: registered shiftout updates on each shift edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0; sr_shiftout <= 1'b0;
    end else if (sr_enable) begin
      if (sr_sclr) begin sr_q <= '0; sr_shiftout <= 1'b0; end
      else if (sr_load) sr_q <= sr_data;
      else begin sr_q <= {sr_q[W-2:0], sr_shiftin}; sr_shiftout <= sr_q[W-1]; end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q2 <= '0; sr_shiftout2 <= 1'b0;
    end else if (sr_enable2) begin
      if (sr_sclr2) begin sr_q2 <= '0; sr_shiftout2 <= 1'b0; end
      else if (sr_load2) sr_q2 <= sr_data2;
      else begin sr_q2 <= {sr_q2[W-2:0], sr_shiftin2}; sr_shiftout2 <= sr_q2[W-1]; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] w, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b    = w[W-1-i];
      e.last = (nbits == W) && (P == 0) && (i == W - 1);
      sb.push_back(e);
    end
    if (nbits == W && P == 1) begin
      e.b    = ^w;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && k < 60) begin
      step();
      k++;
    end
    check("idle_in_time", (k < 60), 1);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    push_frame(w, W);
    step();
    in_valid = 1'b0;
    wait_idle();
  endtask

  // Serial monitor: every qualified bit is popped from the scoreboard, done must mark the last.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (ser_valid === 1'b1) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_bit: observed ser_out %0b expected no bit", ser_out);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("ser_out", ser_out, mon_e.b);
          check("done_on_bit", done, mon_e.last);
        end
      end else begin
        check("done_no_bit", done, 0);
        check("ser_out_idle", ser_out, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_assert = 0; n_fail = 0; mon_en = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; abort2 = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_sr_enable", sr_enable, 0);
    check("rst_sr_data", sr_data, 0);
    check("rst_in_ready2", in_ready, 1);

    // 0xA5 with cycle-exact control checks
    in_valid = 1'b1; in_data = 8'hA5;
    push_frame(8'hA5, W);
    step();
    in_valid = 1'b0; in_data = 8'hFF;
    check("load_c1", sr_load, 1);
    check("load_en_c1", sr_enable, 1);
    check("load_data_c1", sr_data, 8'hA5);
    check("ready_c1", in_ready, 0);
    check("busy_c1", busy, 1);
    step();
    check("load_c2", sr_load, 0);
    check("en_c2", sr_enable, 1);
    check("ser_valid_c2", ser_valid, 0);
    step();
    check("ser_valid_c3", ser_valid, 1);
    repeat (7) step();
    check("done_c10", done, (P == 0) ? 1 : 0);
    check("sr_en_last", sr_enable, 0);
    repeat (1 + P) step();
    check("ready_after_frame", in_ready, 1);
    check("sb_after_a5", sb.size(), 0);

    // back-to-back 0xFF then 0x00 with in_valid held
    in_valid = 1'b1; in_data = 8'hFF;
    push_frame(8'hFF, W);
    step();
    in_data = 8'h00;
    push_frame(8'h00, W);
    for (int i = 1; i < 11 + P; i++) begin
      check("b2b_ready_low_1", in_ready, 0);
      step();
    end
    check("b2b_ready_period", in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 11 + P; i++) begin
      check("b2b_ready_low_2", in_ready, 0);
      step();
    end
    check("b2b_ready_end", in_ready, 1);
    wait_idle();

    // abort at 4th SHIFT cycle of 0xC3: only the first two bits appear
    in_valid = 1'b1; in_data = 8'hC3;
    push_frame(8'hC3, 2);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    #1;
    check("abort_sclr", sr_sclr, 1);
    check("abort_en", sr_enable, 1);
    check("abort_load", sr_load, 0);
    check("abort_ser_valid", ser_valid, 0);
    check("abort_done", done, 0);
    step();
    abort = 1'b0;
    check("abort_busy_next", busy, 0);
    check("abort_ser_valid_next", ser_valid, 0);
    check("abort_ready_next", in_ready, 1);
    check("abort_sb", sb.size(), 0);
    send(8'h3C);

    // abort and in_valid together in IDLE: nothing accepted
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("idle_abort_busy", busy, 0);

    // asynchronous reset in the middle of a SHIFT
    mon_en = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", sr_enable, 0);
    check("mid_rst_ser_valid", ser_valid, 0);
    check("mid_rst_ser_out", ser_out, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_data", sr_data, 0);
    check("mid_rst_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    sb.delete();
    step();
    mon_en = 1'b1;
    check("post_rst_ready", in_ready, 1);
    send(8'h81);

    // parity-relevant words (parity bit checked only when the feature is built in)
    send(8'h07);
    send(8'h0F);

    // inter-frame gap of 3 on the second instance
    in_valid2 = 1'b1; in_data2 = 8'h55;
    check("gap_ready0", in_ready2, 1);
    step();
    k = 1;
    while (in_ready2 !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("gap_period", k, 14 + P);
    step();
    in_valid2 = 1'b0;
    check("gap_busy_second", busy2, 1);

    check("final_sb", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
